// File: rtl/mem_arbiter_rr_pkg.sv
// Shared types for the cache-miss arbiter: FSM state encoding and the
// operation captured when a requester is granted.
package mem_arbiter_rr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    ARB_READ  = 1'b0,
    ARB_WRITE = 1'b1
  } arb_op_t;

endpackage

// File: rtl/mem_arbiter_rr_if.sv
// Bus bundle between the cache-miss requesters, the arbiter and the
// cacheline adapter.
//
// Handshake: a requester raises req_read_i[p] or req_write_i[p] (never both)
// with a stable address/line and holds it until it sees a one-cycle
// req_resp_o[p] pulse; req_rdata_o is valid only during that pulse. Toward the
// adapter, mem_read_o/mem_write_o stay high with stable mem_addr_o/mem_wdata_o
// until the adapter pulses mem_resp_i for one cycle, with mem_rdata_i valid in
// that same cycle.
interface mem_arbiter_rr_if #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
);

  logic [NUM_PORTS-1:0]            req_read_i;
  logic [NUM_PORTS-1:0]            req_write_i;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr_i;
  logic [NUM_PORTS*LINE_WIDTH-1:0] req_wdata_i;
  logic [NUM_PORTS-1:0]            req_resp_o;
  logic [LINE_WIDTH-1:0]           req_rdata_o;
  logic                            mem_read_o;
  logic                            mem_write_o;
  logic [ADDR_WIDTH-1:0]           mem_addr_o;
  logic [LINE_WIDTH-1:0]           mem_wdata_o;
  logic                            mem_resp_i;
  logic [LINE_WIDTH-1:0]           mem_rdata_i;
  logic [NUM_PORTS-1:0]            grant_o;
  logic                            busy_o;

  // Requesters plus adapter side.
  modport master (
    output req_read_i, req_write_i, req_addr_i, req_wdata_i,
    output mem_resp_i, mem_rdata_i,
    input  req_resp_o, req_rdata_o, mem_read_o, mem_write_o,
    input  mem_addr_o, mem_wdata_o, grant_o, busy_o
  );

  // Arbiter side.
  modport slave (
    input  req_read_i, req_write_i, req_addr_i, req_wdata_i,
    input  mem_resp_i, mem_rdata_i,
    output req_resp_o, req_rdata_o, mem_read_o, mem_write_o,
    output mem_addr_o, mem_wdata_o, grant_o, busy_o
  );

endinterface

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational winner selection. In round-robin mode the search starts one
// past the previous winner and wraps; in fixed mode the lowest index wins.
module rr_priority_picker
  import mem_arbiter_rr_pkg::*;
#(
  parameter int N       = 2,
  parameter int RR_MODE = 1,
  localparam int IW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_winner,
  output logic          valid,
  output logic [IW-1:0] winner,
  output logic [N-1:0]  grant
);

  // One extra bit so last_winner + offset can exceed N before wrapping.
  localparam logic [IW:0] NUM_C = (IW+1)'(N);

  logic [IW:0] cand;

  // Scan candidates in priority order; first requesting one wins.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    grant  = '0;
    cand   = '0;
    for (int k = 0; k < N; k++) begin
      cand = (RR_MODE != 0) ? ({1'b0, last_winner} + (IW+1)'(k + 1))
                            : (IW+1)'(k);
      if (cand >= NUM_C) cand = cand - NUM_C;
      if (!valid && req[cand[IW-1:0]]) begin
        valid  = 1'b1;
        winner = cand[IW-1:0];
      end
    end
    if (valid) grant[winner] = 1'b1;
  end

endmodule

// File: rtl/mem_arbiter_rr.sv
// Arbitrates NUM_PORTS cache-miss requesters onto one line-wide adapter port.
// The winner's request is registered at grant and the grant is held for the
// whole IDLE -> BUSY -> RESP transaction.
module mem_arbiter_rr
  import mem_arbiter_rr_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256,
  parameter int RR_MODE    = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  mem_arbiter_rr_if.slave   bus,
  output logic [1:0]        state_o
);

  localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_BUSY = BUSY;
  localparam logic [1:0] S_RESP = RESP;

  logic [1:0]            state;
  logic [IW-1:0]         winner_q;
  logic [IW-1:0]         last_winner;
  arb_op_t               op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] wdata_q;
  logic [LINE_WIDTH-1:0] rdata_q;
  logic [NUM_PORTS-1:0]  grant_q;
  logic [NUM_PORTS-1:0]  resp_vec;

  logic [NUM_PORTS-1:0]  requesting;
  logic                  pick_valid;
  logic [IW-1:0]         pick_winner;
  logic [NUM_PORTS-1:0]  pick_grant;

  logic [ADDR_WIDTH-1:0] port_addr  [NUM_PORTS];
  logic [LINE_WIDTH-1:0] port_wdata [NUM_PORTS];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack
    assign port_addr[p]  = bus.req_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
    assign port_wdata[p] = bus.req_wdata_i[p*LINE_WIDTH +: LINE_WIDTH];
  end

  assign requesting = bus.req_read_i | bus.req_write_i;

  rr_priority_picker #(
    .N       (NUM_PORTS),
    .RR_MODE (RR_MODE)
  ) u_picker (
    .req         (requesting),
    .last_winner (last_winner),
    .valid       (pick_valid),
    .winner      (pick_winner),
    .grant       (pick_grant)
  );

  // Transaction FSM; all request fields are captured once, at grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      winner_q    <= '0;
      last_winner <= IW'(NUM_PORTS - 1);
      op_q        <= ARB_READ;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      grant_q     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_valid) begin
            state       <= S_BUSY;
            winner_q    <= pick_winner;
            last_winner <= pick_winner;
            // A port raising both lines is treated as a write.
            op_q        <= bus.req_write_i[pick_winner] ? ARB_WRITE : ARB_READ;
            addr_q      <= port_addr[pick_winner];
            wdata_q     <= port_wdata[pick_winner];
            grant_q     <= pick_grant;
          end
        end
        S_BUSY: begin
          if (bus.mem_resp_i) begin
            rdata_q <= bus.mem_rdata_i;
            state   <= S_RESP;
          end
        end
        S_RESP: begin
          state   <= S_IDLE;
          grant_q <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Completion pulse goes only to the registered winner.
  always_comb begin
    resp_vec = '0;
    if (state == S_RESP) resp_vec[winner_q] = 1'b1;
  end

  assign bus.req_resp_o  = resp_vec;
  assign bus.req_rdata_o = rdata_q;
  assign bus.mem_read_o  = (state == S_BUSY) && (op_q == ARB_READ);
  assign bus.mem_write_o = (state == S_BUSY) && (op_q == ARB_WRITE);
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_wdata_o = wdata_q;
  assign bus.grant_o     = grant_q;
  assign bus.busy_o      = (state != S_IDLE);
  assign state_o         = state;

  // A requester must never ask for a read and a write at the same time.
  a_no_dual_op: assert property (@(posedge clk) disable iff (!reset_n)
    (bus.req_read_i & bus.req_write_i) == '0);

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Bench for mem_arbiter_rr: a round-robin and a fixed-priority instance run
// in lockstep from shared clock, reset and adapter; each has its own
// requesters and a transaction-level reference model.
module tb_mem_arbiter_rr;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int LW = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- DUTs ----------------
  mem_arbiter_rr_if #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus_rr ();
  mem_arbiter_rr_if #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus_fp ();
  logic [1:0] state_rr, state_fp;

  mem_arbiter_rr #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .RR_MODE(1)) u_rr (
    .clk(clk), .reset_n(reset_n), .bus(bus_rr.slave), .state_o(state_rr));
  mem_arbiter_rr #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .RR_MODE(0)) u_fp (
    .clk(clk), .reset_n(reset_n), .bus(bus_fp.slave), .state_o(state_fp));

  logic [N-1:0]    drv_rd [2];
  logic [N-1:0]    drv_wr [2];
  logic [N*AW-1:0] drv_addr [2];
  logic [N*LW-1:0] drv_wdata [2];
  logic            mem_resp;
  logic [LW-1:0]   mem_rdata;

  assign bus_rr.req_read_i  = drv_rd[0];
  assign bus_rr.req_write_i = drv_wr[0];
  assign bus_rr.req_addr_i  = drv_addr[0];
  assign bus_rr.req_wdata_i = drv_wdata[0];
  assign bus_rr.mem_resp_i  = mem_resp;
  assign bus_rr.mem_rdata_i = mem_rdata;
  assign bus_fp.req_read_i  = drv_rd[1];
  assign bus_fp.req_write_i = drv_wr[1];
  assign bus_fp.req_addr_i  = drv_addr[1];
  assign bus_fp.req_wdata_i = drv_wdata[1];
  assign bus_fp.mem_resp_i  = mem_resp;
  assign bus_fp.mem_rdata_i = mem_rdata;

  logic [N-1:0]  obs_resp [2];
  logic [N-1:0]  obs_grant [2];
  logic [LW-1:0] obs_rdata [2];
  logic [LW-1:0] obs_wdata [2];
  logic [AW-1:0] obs_addr [2];
  logic          obs_rd [2];
  logic          obs_wr [2];
  logic          obs_busy [2];
  logic [1:0]    obs_state [2];

  assign obs_resp[0]  = bus_rr.req_resp_o;
  assign obs_grant[0] = bus_rr.grant_o;
  assign obs_rdata[0] = bus_rr.req_rdata_o;
  assign obs_wdata[0] = bus_rr.mem_wdata_o;
  assign obs_addr[0]  = bus_rr.mem_addr_o;
  assign obs_rd[0]    = bus_rr.mem_read_o;
  assign obs_wr[0]    = bus_rr.mem_write_o;
  assign obs_busy[0]  = bus_rr.busy_o;
  assign obs_state[0] = state_rr;
  assign obs_resp[1]  = bus_fp.req_resp_o;
  assign obs_grant[1] = bus_fp.grant_o;
  assign obs_rdata[1] = bus_fp.req_rdata_o;
  assign obs_wdata[1] = bus_fp.mem_wdata_o;
  assign obs_addr[1]  = bus_fp.mem_addr_o;
  assign obs_rd[1]    = bus_fp.mem_read_o;
  assign obs_wr[1]    = bus_fp.mem_write_o;
  assign obs_busy[1]  = bus_fp.busy_o;
  assign obs_state[1] = state_fp;

  // ---------------- reference model ----------------
  bit            pend [2][N];
  bit            pop [2][N];   // 1 = write
  logic [AW-1:0] paddr [2][N];
  logic [LW-1:0] pdata [2][N];
  int            last_rr;
  int            win [2];

  // ---------------- scoreboard ----------------
  logic [LW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic string nm(input int d);
    return (d == 0) ? "rr" : "fp";
  endfunction

  function automatic logic [N-1:0] onehot(input int w);
    logic [N-1:0] r;
    r = '0;
    r[w] = 1'b1;
    return r;
  endfunction

  function automatic bit any_pend(input int d);
    for (int p = 0; p < N; p++) if (pend[d][p]) return 1'b1;
    return 1'b0;
  endfunction

  // Round-robin: first pending port after the previous winner, wrapping.
  // Fixed: lowest pending port.
  function automatic int pick(input int d);
    if (d == 0) begin
      for (int i = 1; i <= N; i++) if (pend[0][(last_rr + i) % N]) return (last_rr + i) % N;
    end else begin
      for (int p = 0; p < N; p++) if (pend[1][p]) return p;
    end
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_port(input int d, input int p);
    drv_rd[d][p] = pend[d][p] && !pop[d][p];
    drv_wr[d][p] = pend[d][p] && pop[d][p];
    drv_addr[d][p*AW +: AW]  = paddr[d][p];
    drv_wdata[d][p*LW +: LW] = pdata[d][p];
  endtask

  task automatic new_req(input int d, input int p);
    pend[d][p]  = 1'b1;
    pop[d][p]   = 1'($urandom_range(0, 1));
    paddr[d][p] = $urandom;
    pdata[d][p] = {$urandom, $urandom};
    drive_port(d, p);
  endtask

  task automatic maybe_request(input int d, input int pct);
    for (int p = 0; p < N; p++)
      if (!pend[d][p] && $urandom_range(0, 99) < pct) new_req(d, p);
  endtask

  task automatic check_reset(input int d);
    check_eq({nm(d), " rst resp"},  obs_resp[d], '0);
    check_eq({nm(d), " rst rdata"}, obs_rdata[d], '0);
    check_eq({nm(d), " rst rd"},    obs_rd[d], '0);
    check_eq({nm(d), " rst wr"},    obs_wr[d], '0);
    check_eq({nm(d), " rst addr"},  obs_addr[d], '0);
    check_eq({nm(d), " rst wdata"}, obs_wdata[d], '0);
    check_eq({nm(d), " rst grant"}, obs_grant[d], '0);
    check_eq({nm(d), " rst busy"},  obs_busy[d], '0);
    check_eq({nm(d), " rst state"}, obs_state[d], '0);
  endtask

  task automatic check_idle(input int d);
    check_eq({nm(d), " idle grant"}, obs_grant[d], '0);
    check_eq({nm(d), " idle busy"},  obs_busy[d], '0);
    check_eq({nm(d), " idle resp"},  obs_resp[d], '0);
    check_eq({nm(d), " idle rd"},    obs_rd[d], '0);
    check_eq({nm(d), " idle wr"},    obs_wr[d], '0);
    check_eq({nm(d), " idle state"}, obs_state[d], '0);
  endtask

  task automatic check_busy(input int d);
    int w;
    w = win[d];
    check_eq({nm(d), " busy grant"}, obs_grant[d], onehot(w));
    check_eq({nm(d), " busy flag"},  obs_busy[d], 1'b1);
    check_eq({nm(d), " busy rd"},    obs_rd[d], !pop[d][w]);
    check_eq({nm(d), " busy wr"},    obs_wr[d], pop[d][w]);
    check_eq({nm(d), " busy addr"},  obs_addr[d], paddr[d][w]);
    check_eq({nm(d), " busy wdata"}, obs_wdata[d], pdata[d][w]);
    check_eq({nm(d), " busy resp"},  obs_resp[d], '0);
  endtask

  // One full transaction on both DUTs, entered and left at a negedge in an
  // IDLE cycle. With do_reset the transaction is aborted by reset in BUSY.
  task automatic txn(input bit do_reset, input bit sat);
    logic [LW-1:0] exp_data;
    for (int d = 0; d < 2; d++) begin
      if (sat) maybe_request(d, 100);
      if (!any_pend(d)) new_req(d, $urandom_range(0, N-1));
    end
    for (int d = 0; d < 2; d++) win[d] = pick(d);
    last_rr = win[0];
    @(negedge clk);
    for (int d = 0; d < 2; d++) check_busy(d);
    if (do_reset) begin
      #2 reset_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) check_reset(d);
      @(negedge clk);
      for (int d = 0; d < 2; d++) for (int p = 0; p < N; p++) new_req(d, p);
      last_rr = N - 1;
      @(negedge clk);
      for (int d = 0; d < 2; d++) check_reset(d);
      reset_n = 1'b1;
      return;
    end
    // Granted port scribbles over its inputs; the DUT must ignore this.
    for (int d = 0; d < 2; d++) begin
      drv_addr[d][win[d]*AW +: AW]  = $urandom;
      drv_wdata[d][win[d]*LW +: LW] = {$urandom, $urandom};
      maybe_request(d, 30);
    end
    repeat ($urandom_range(0, 3)) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        check_busy(d);
        maybe_request(d, 20);
      end
    end
    mem_resp  = 1'b1;
    mem_rdata = {$urandom, $urandom};
    exp_q.push_back(mem_rdata);
    @(negedge clk);
    mem_resp  = 1'b0;
    mem_rdata = {$urandom, $urandom};
    exp_data  = exp_q.pop_front();
    for (int d = 0; d < 2; d++) begin
      check_eq({nm(d), " resp pulse"}, obs_resp[d], onehot(win[d]));
      check_eq({nm(d), " resp rdata"}, obs_rdata[d], exp_data);
      check_eq({nm(d), " resp rd"},    obs_rd[d], '0);
      check_eq({nm(d), " resp wr"},    obs_wr[d], '0);
      check_eq({nm(d), " resp grant"}, obs_grant[d], onehot(win[d]));
      check_eq({nm(d), " resp busy"},  obs_busy[d], 1'b1);
      pend[d][win[d]] = 1'b0;
      drive_port(d, win[d]);
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) check_idle(d);
  endtask

  // Adapter response while idle with nobody requesting must be ignored.
  task automatic idle_blip();
    mem_resp  = 1'b1;
    mem_rdata = {$urandom, $urandom};
    @(negedge clk);
    mem_resp = 1'b0;
    for (int d = 0; d < 2; d++) check_idle(d);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset_n   = 1'b0;
    mem_resp  = 1'b0;
    mem_rdata = '0;
    last_rr   = N - 1;
    for (int d = 0; d < 2; d++) begin
      drv_rd[d] = '0;
      drv_wr[d] = '0;
      drv_addr[d] = '0;
      drv_wdata[d] = '0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) check_reset(d);
    reset_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) check_idle(d);

    // Every port requesting continuously: rr must rotate 0,1,2,3,0,...
    // while fixed priority keeps serving port 0.
    for (int t = 0; t < 8; t++) txn(1'b0, 1'b1);

    for (int t = 0; t < 150; t++) begin
      if (!any_pend(0) && !any_pend(1) && $urandom_range(0, 1) == 1) idle_blip();
      txn(t == 60 || t == 120, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
